// File: rtl/serial_pkg.sv
// Shared types and constants for the serial echo/loopback slice.
package serial_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_REV  = 2'd1,
        MODE_ADD  = 2'd2,
        MODE_DROP = 2'd3
    } echo_mode_e;

    typedef logic [7:0] byte_t;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/serial_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate count register.
module serial_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Empty head reads as zero so the output is clean out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/serial_echo_fifo.sv
// Buffered loopback core between serial_interface RX and TX with a per-word
// transform applied on accept. Define SERIAL_ECHO_STATS_EN for rx/tx counters.
module serial_echo_fifo
    import serial_pkg::*;
#(
    parameter int unsigned BYTES   = 1,
    parameter int unsigned DEPTH   = 16,
    parameter byte_t       ADD_VAL = 8'h01
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  echo_mode_e                 mode,
    input  logic [BYTES*8-1:0]         s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [BYTES*8-1:0]         m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           rx_cnt,
    output logic [CNT_W-1:0]           tx_cnt
);

    localparam int unsigned W = BYTES * 8;

    logic         full;
    logic         empty;
    logic         accept;
    logic         deliver;
    logic         push;
    logic [W-1:0] xf_data;

    assign s_ready = !full;
    assign m_valid = !empty;
    assign accept  = s_valid && s_ready;
    assign deliver = m_valid && m_ready;
    assign push    = accept && (mode != MODE_DROP);

    always_comb begin
        xf_data = s_data;
        for (int unsigned i = 0; i < BYTES; i++) begin
            case (mode)
                MODE_REV: xf_data[i*8 +: 8] = s_data[(BYTES-1-i)*8 +: 8];
                MODE_ADD: xf_data[i*8 +: 8] = s_data[i*8 +: 8] + ADD_VAL;
                default:  ;
            endcase
        end
    end

    serial_sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_data (xf_data),
        .pop       (deliver),
        .pop_data  (m_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drop_cnt <= '0;
        end else if (accept && (mode == MODE_DROP) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef SERIAL_ECHO_STATS_EN
    logic [CNT_W-1:0] rx_q;
    logic [CNT_W-1:0] tx_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_q <= '0;
            tx_q <= '0;
        end else begin
            if (accept)  rx_q <= rx_q + 1'b1;
            if (deliver) tx_q <= tx_q + 1'b1;
        end
    end

    assign rx_cnt = rx_q;
    assign tx_cnt = tx_q;
`else
    assign rx_cnt = '0;
    assign tx_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_echo_fifo.sv
// Directed self-checking bench for serial_echo_fifo (byte-wide and word-wide instances).
module tb_serial_echo_fifo;
    import serial_pkg::*;

    logic        clk;
    logic        nrst;

    echo_mode_e  mode8;
    logic [7:0]  s_data8;
    logic        s_valid8;
    logic        s_ready8;
    logic [7:0]  m_data8;
    logic        m_valid8;
    logic        m_ready8;
    logic [4:0]  level8;
    logic [15:0] drop8;
    logic [15:0] rx8;
    logic [15:0] tx8;

    echo_mode_e  mode32;
    logic [31:0] s_data32;
    logic        s_valid32;
    logic        s_ready32;
    logic [31:0] m_data32;
    logic        m_valid32;
    logic        m_ready32;
    logic [2:0]  level32;
    logic [15:0] drop32;
    logic [15:0] rx32;
    logic [15:0] tx32;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    serial_echo_fifo #(
        .BYTES   (1),
        .DEPTH   (16),
        .ADD_VAL (8'h01)
    ) u_dut8 (
        .clk      (clk),
        .nrst     (nrst),
        .mode     (mode8),
        .s_data   (s_data8),
        .s_valid  (s_valid8),
        .s_ready  (s_ready8),
        .m_data   (m_data8),
        .m_valid  (m_valid8),
        .m_ready  (m_ready8),
        .level    (level8),
        .drop_cnt (drop8),
        .rx_cnt   (rx8),
        .tx_cnt   (tx8)
    );

    serial_echo_fifo #(
        .BYTES   (4),
        .DEPTH   (4),
        .ADD_VAL (8'h01)
    ) u_dut32 (
        .clk      (clk),
        .nrst     (nrst),
        .mode     (mode32),
        .s_data   (s_data32),
        .s_valid  (s_valid32),
        .s_ready  (s_ready32),
        .m_data   (m_data32),
        .m_valid  (m_valid32),
        .m_ready  (m_ready32),
        .level    (level32),
        .drop_cnt (drop32),
        .rx_cnt   (rx32),
        .tx_cnt   (tx32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst      = 1'b0;
        mode8     = MODE_PASS;
        s_data8   = '0;
        s_valid8  = 1'b0;
        m_ready8  = 1'b1;
        mode32    = MODE_PASS;
        s_data32  = '0;
        s_valid32 = 1'b0;
        m_ready32 = 1'b1;

        // Reset state
        #12;
        check("rst_m_valid", m_valid8, 0);
        check("rst_level",   level8,   0);
        check("rst_m_data",  m_data8,  0);
        check("rst_drop",    drop8,    0);
        check("rst_rx",      rx8,      0);
        check("rst_tx",      tx8,      0);
        nrst = 1'b1;
        step();
        check("rst_s_ready", s_ready8, 1);

        // Back-to-back PASS: 0x41,0x42,0x43
        s_valid8 = 1'b1;
        s_data8  = 8'h41;
        #1;
        check("lat_no_bypass", m_valid8, 0);
        step();
        check("p1_valid", m_valid8, 1);
        check("p1_data",  m_data8,  8'h41);
        check("p1_level", level8,   1);
        s_data8 = 8'h42;
        step();
        check("p2_data",  m_data8,  8'h42);
        check("p2_level", level8,   1);
        s_data8 = 8'h43;
        step();
        check("p3_data",  m_data8,  8'h43);
        check("p3_level", level8,   1);
        s_valid8 = 1'b0;
        step();
        check("p_drained_valid", m_valid8, 0);
        check("p_drained_level", level8,   0);

        // ADD on byte-wide instance: 0xFF wraps to 0x00
        mode8    = MODE_ADD;
        s_valid8 = 1'b1;
        s_data8  = 8'hFF;
        step();
        s_valid8 = 1'b0;
        mode8    = MODE_PASS;
        check("add8_wrap", m_data8, 8'h00);
        step();

        // Word-wide REV then ADD back-to-back
        mode32    = MODE_REV;
        s_valid32 = 1'b1;
        s_data32  = 32'h11223344;
        step();
        check("rev32", m_data32, 32'h44332211);
        mode32   = MODE_ADD;
        s_data32 = 32'hFF00FE01;
        step();
        check("add32", m_data32, 32'h0001FF02);
        s_valid32 = 1'b0;
        step();
        check("w32_empty", m_valid32, 0);

        // Mode change does not alter an already queued word
        m_ready32 = 1'b0;
        mode32    = MODE_REV;
        s_valid32 = 1'b1;
        s_data32  = 32'hA1B2C3D4;
        step();
        s_valid32 = 1'b0;
        mode32    = MODE_ADD;
        #1;
        check("queued_stable", m_data32, 32'hD4C3B2A1);
        m_ready32 = 1'b1;
        step();
        check("queued_popped", m_valid32, 0);

        // Fill to DEPTH with m_ready low
        m_ready8 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid8 = 1'b1;
            s_data8  = 8'(8'h10 + i);
            check("fill_ready", s_ready8, 1);
            step();
        end
        check("full_level", level8,   16);
        check("full_ready", s_ready8, 0);
        s_data8 = 8'h20;
        step();
        check("held_level", level8,   16);
        check("held_ready", s_ready8, 0);
        m_ready8 = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check("drain_valid", m_valid8, 1);
            check("drain_data",  m_data8,  32'(8'h10 + k));
            if (k == 0) check("no_pop_bypass", s_ready8, 0);
            if (k == 1) begin
                check("ready_after_pop", s_ready8, 1);
                check("level_after_pop", level8,   15);
            end
            step();
            if (k == 1) s_valid8 = 1'b0;
        end
        check("drain_level", level8,   0);
        check("drain_empty", m_valid8, 0);

        // Queue 3 in PASS, then drop 5
        m_ready8 = 1'b0;
        s_valid8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data8 = 8'(8'h31 + i);
            step();
        end
        mode8 = MODE_DROP;
        for (int i = 0; i < 5; i++) begin
            s_data8 = 8'(8'h90 + i);
            step();
        end
        s_valid8 = 1'b0;
        mode8    = MODE_PASS;
        check("drop_level", level8, 3);
        check("drop_cnt",   drop8,  5);
        m_ready8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("drop_out_data", m_data8, 32'(8'h31 + k));
            step();
        end
        check("drop_end_level", level8,   0);
        check("drop_end_valid", m_valid8, 0);

        // Asynchronous reset with 7 words queued
        m_ready8 = 1'b0;
        s_valid8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_data8 = 8'(8'h60 + i);
            step();
        end
        s_valid8 = 1'b0;
        check("pre_rst_level", level8,   7);
        check("pre_rst_valid", m_valid8, 1);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_valid", m_valid8, 0);
        check("arst_level", level8,   0);
        check("arst_data",  m_data8,  0);
        check("arst_drop",  drop8,    0);
        #3;
        nrst = 1'b1;
        step();
        m_ready8 = 1'b1;
        s_valid8 = 1'b1;
        s_data8  = 8'h5A;
        step();
        s_valid8 = 1'b0;
        check("post_rst_data",  m_data8,  8'h5A);
        check("post_rst_valid", m_valid8, 1);
        step();
        check("post_rst_empty", m_valid8, 0);

        // Statistics counters over 70000 words
        nrst = 1'b0;
        #3;
        nrst = 1'b1;
        step();
        mode8    = MODE_PASS;
        m_ready8 = 1'b1;
        s_valid8 = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            s_data8 = 8'(i);
            step();
        end
        s_valid8 = 1'b0;
        step();
        step();
        check("stats_level", level8, 0);
`ifdef SERIAL_ECHO_STATS_EN
        check("stats_rx", rx8, 16'd4464);
        check("stats_tx", tx8, 16'd4464);
`else
        check("stats_rx_off", rx8, 0);
        check("stats_tx_off", tx8, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_echo_fifo.md
Name: serial_echo_fifo

Overview:
- Parametrised loopback/transform core that replaces the direct wire loop between serial_interface's receive side (o_*) and transmit side (i_*).
- Buffers received words in a FIFO and applies a run-time selectable per-word transform.
- Decouples RX bursts from TX back-pressure.
- Word width follows the serial_interface byte-count parameters.

Parameters:
- BYTES, 1, word width in bytes; matches I_BYTES/O_BYTES of the attached serial_interface.
- DEPTH, 16, FIFO depth in words; power of two, ≥2.
- ADD_VAL, 8'h01, constant added to each byte in MODE_ADD.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous assert, active-low.
- mode  in  2  transform select, echo_mode_e.
- s_data  in  BYTES*8  received word (from serial_interface o_data).
- s_valid  in  1  received word valid.
- s_ready  out  1  core can accept a word.
- m_data  out  BYTES*8  word to transmit (to serial_interface i_data).
- m_valid  out  1  transmit word valid.
- m_ready  in  1  transmitter accepts word.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  16  words discarded in MODE_DROP.
- rx_cnt  out  16  words accepted on s_*; stats feature only.
- tx_cnt  out  16  words delivered on m_*; stats feature only.

Behaviour:
- Reset (nrst low, async): FIFO emptied; rd_ptr = wr_ptr = 0; level = 0; m_valid = 0; s_ready = 1 once nrst deasserts; drop_cnt = rx_cnt = tx_cnt = 0; m_data = 0.
- Reset mid-transfer discards all buffered words; there is no partial-word state.
- Handshakes are AXI-stream style:
  - Transfer occurs on the clk edge where valid && ready.
  - Valid, once raised, holds with stable data until accepted; m_valid never drops without m_ready.
- Accept: s_ready = (level < DEPTH). No pop-bypass: when full, a same-cycle pop does not raise s_ready in that cycle.
- Transform is applied at accept time using the mode value sampled on the accepting edge. A mode change never alters words already queued.
  - MODE_PASS (0): word unchanged.
  - MODE_REV (1): byte order reversed; byte i goes to BYTES-1-i. Identity when BYTES=1.
  - MODE_ADD (2): each byte += ADD_VAL modulo 256; no carry between bytes.
  - MODE_DROP (3): word accepted (s_ready rules still apply) but not written. drop_cnt increments, saturating at 16'hFFFF.
- Latency: a word accepted at edge N is visible on m_data/m_valid after edge N (registered FIFO, first-word-fall-through). Minimum 1 cycle input to output.
- Throughput: 1 word/cycle sustained when not full and m_ready = 1.
- Simultaneous push and pop:
  - Not full, not empty: level unchanged; both pointers advance.
  - Empty: no bypass; the word appears on the following cycle.
- Pointers are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
- level = wr_ptr - rd_ptr in the same width.

Optional Feature:
- SERIAL_ECHO_STATS_EN defined: rx_cnt and tx_cnt count accepted and delivered words, 16-bit, wrap-around (not saturating). Reset to 0.
- Undefined: rx_cnt and tx_cnt tie to 0 and no counter flops are inferred. drop_cnt is always present.

Decomposition:
- serial_pkg holds:
  - typedef enum logic [1:0] echo_mode_e {MODE_PASS, MODE_REV, MODE_ADD, MODE_DROP};
  - typedef logic [7:0] byte_t;
  - localparam CNT_W = 16.
- One sub-module, serial_sync_fifo (parameters WIDTH, DEPTH; same clk/nrst; push/pop/full/empty/level). Reusable for a future TX-side buffer.
- The transform and counters stay in serial_echo_fifo.

Test Plan:
- Reset with BYTES=1, DEPTH=16, MODE_PASS, m_ready=1; send 0x41,0x42,0x43 back-to-back → m_data 0x41,0x42,0x43 on consecutive cycles, first one cycle after its accept; level peaks at 1.
- BYTES=4, MODE_REV, send 0x11223344 → m_data 0x44332211. MODE_ADD with ADD_VAL=1, send 0xFF00FE01 → m_data 0x0001FF02 (per-byte wrap, no carry).
- m_ready=0, push 17 words into DEPTH=16 → s_ready drops after the 16th accept, level=16, 17th word held off. Then raise m_ready → 16 words out in order, s_ready returns after the first pop.
- Queue 3 words in PASS, switch to MODE_DROP, send 5 more → only the 3 queued words emerge, drop_cnt=5, level returns to 0.
- Assert nrst low asynchronously with level=7 and m_valid=1 → m_valid and level are 0 immediately, without a clock edge. After release, a new word 0x5A passes normally.
- With SERIAL_ECHO_STATS_EN: 70000 words in PASS → rx_cnt = tx_cnt = 70000 mod 65536 = 4464. Without the macro, both read 0 throughout.
